hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 8-bit RISC core; sits beside the ID stage.
//  Compares 2-bit register addresses from ID, EX, MEM and WB; produces forwarding selects.
//  Drives the En/flush controls of the downstream 2-bit/8-bit pipeline registers.
//  Sequences multi-cycle branch flushes and data-memory wait freezes.
// PARAMETERS
//  REG_AW       2   register address width (4 GPRs, all writable, no hardwired zero)
//  FLUSH_CYCLES 1   bubbles inserted after taken branch; legal 1..3
//  CNT_W        16  width of perf counters (only with HAZ_PERF_CNT_EN)
// PORTS
//  CLK          in  1       clock, rising edge
//  RST          in  1       reset, asynchronous, active-high
//  id_rs1       in  REG_AW  ID source reg A;  id_rs1_used in 1: A is read
//  id_rs2       in  REG_AW  ID source reg B;  id_rs2_used in 1: B is read
//  ex_rd        in  REG_AW  EX dest; ex_reg_write in 1; ex_mem_read in 1 (EX is load)
//  mem_rd       in  REG_AW  MEM dest; mem_reg_write in 1
//  wb_rd        in  REG_AW  WB dest;  wb_reg_write in 1
//  br_taken     in  1       taken branch resolved in EX
//  dmem_busy    in  1       data memory not ready, MEM must hold
//  pc_en        out 1       PC enable
//  ifid_en      out 1       IF/ID enable;  ifid_flush out 1: load NOP into IF/ID
//  idex_en      out 1       ID/EX enable;  idex_flush out 1: load bubble into ID/EX
//  exmem_en     out 1       EX/MEM and MEM/WB enable
//  fwd_a/fwd_b  out 2       operand select for EX: 00 regfile, 01 MEM stage, 10 WB stage
//  stall_cnt    out CNT_W   load-use + mem-wait stall cycles
//  flush_cnt    out CNT_W   branch bubble cycles
// BEHAVIOUR
//  - Controls are combinational from state + inputs; state/counters update on CLK.
//  - Forwarding (EX uses ID/EX copies of rs): MEM match with mem_reg_write -> 01,
//    else WB match with wb_reg_write -> 10, else 00. MEM beats WB on equal rd.
//  - FSM states: RUN, FLUSH (remaining-bubble counter), WAIT (saved return state).
//  - Priority each cycle: RST > dmem_busy > br_taken > load-use.
//  - dmem_busy=1: all *_en=0; flushes=0; go/stay WAIT.
//    Save RUN/FLUSH and counter; counter frozen. Restore in the cycle after busy drops.
//  - br_taken in RUN: ifid_flush=idex_flush=1; all en=1.
//    If FLUSH_CYCLES>1, enter FLUSH with cnt=FLUSH_CYCLES-1.
//  - FLUSH: ifid_flush=1 per cycle, cnt-1; cnt==1 -> RUN.
//    br_taken here reloads cnt (no lost flush).
//  - Load-use (RUN, no branch): ex_mem_read & ex_reg_write & rd matches a used rs.
//    -> pc_en=ifid_en=0, idex_flush=1, one cycle. Resolved next cycle via fwd 01. No state change.
//  - Normal RUN: all en=1, flushes=0.
//  - While RST=1: all en=0, ifid_flush=idex_flush=1, fwd=00, counters 0, state RUN.
//    Mid-flush/mid-wait reset aborts to RUN.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: stall_cnt/flush_cnt count, saturating at all-ones.
//    stall_cnt +1 per load-use or WAIT cycle; flush_cnt +1 per cycle with ifid_flush=1.
//  Not defined: ports remain, driven constant 0; no counter flops.
// STRUCTURE
//  Shared header core_defs.vh: FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
//  core_defs.vh also holds HZ_RUN/HZ_FLUSH/HZ_WAIT encodings and REG_AW.
//  One sub-module: fwd_sel_unit (combinational rs-vs-rd compare, priority select).
//  fwd_sel_unit is instantiated twice, for operand A and operand B.
// TESTING
//  1 ex_mem_read=1, ex_rd=2, id_rs1=2 used -> 1 cycle pc_en=ifid_en=0, idex_flush=1.
//    Next cycle mem_rd=2 -> fwd_a=01.
//  2 mem_rd=wb_rd=3, both write, rs2=3 -> fwd_b=01. Clear mem_reg_write -> fwd_b=10.
//  3 FLUSH_CYCLES=3, br_taken 1 cycle -> ifid_flush high 3 consecutive cycles.
//    idex_flush high first cycle only. Then RUN.
//  4 dmem_busy 4 cycles during FLUSH (cnt=1) -> all en=0 for 4 cycles.
//    Then exactly 1 more flush cycle.
//  5 br_taken and load-use together -> branch flush only, no stall. Then RST mid-WAIT:
//    outputs go to reset values immediately; RUN after release.
//  6 HAZ_PERF_CNT_EN: 2 load-use + 3 busy cycles -> stall_cnt=5. Undefined -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select codes,
// controller state encodings and register-address width.
package hazard_ctrl_pkg;

  localparam int REG_AW = 2;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'b00,
    HZ_FLUSH = 2'b01,
    HZ_WAIT  = 2'b10
  } hz_state_e;

  // True when a read source register is produced by a writing destination.
  function automatic logic reg_hit(input logic [REG_AW-1:0] rs, input logic rs_used,
                                   input logic [REG_AW-1:0] rd, input logic rd_write);
    return rs_used && rd_write && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel_unit.sv
// Operand forwarding select: the MEM stage result wins over the WB stage result
// when both write the same register.
module fwd_sel_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic [1:0]        fwd
);

  // Priority compare of rs against the younger (MEM) then older (WB) producer.
  always_comb begin
    fwd = FWD_NONE;
    if (reg_hit(rs, 1'b1, mem_rd, mem_reg_write)) begin
      fwd = FWD_MEM;
    end else if (reg_hit(rs, 1'b1, wb_rd, wb_reg_write)) begin
      fwd = FWD_WB;
    end else begin
      fwd = FWD_NONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush and dmem wait.
// Define HAZ_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_used,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              br_taken,
  input  logic              dmem_busy,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic       MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  hz_state_e   state_r, state_nx_s, saved_r, saved_nx_s, eff_state_s;
  logic [1:0]  cnt_r, cnt_nx_s;
  logic [1:0]  fwd_a_s, fwd_b_s;
  logic        load_use_s;

  fwd_sel_unit u_fwd_a (
    .rs(id_rs1), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .fwd(fwd_a_s)
  );

  fwd_sel_unit u_fwd_b (
    .rs(id_rs2), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .fwd(fwd_b_s)
  );

  assign fwd_a = RST ? FWD_NONE : fwd_a_s;
  assign fwd_b = RST ? FWD_NONE : fwd_b_s;

  assign load_use_s = ex_mem_read &&
                      (reg_hit(id_rs1, id_rs1_used, ex_rd, ex_reg_write) ||
                       reg_hit(id_rs2, id_rs2_used, ex_rd, ex_reg_write));

  // The cycle busy drops already behaves as the saved state, so no bubble is lost.
  assign eff_state_s = (state_r == HZ_WAIT) ? saved_r : state_r;

  // Pipeline controls and next-state decode, priority RST > busy > branch > load-use.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_nx_s = state_r;
    saved_nx_s = saved_r;
    cnt_nx_s   = cnt_r;
    if (RST) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_nx_s = HZ_RUN;
      saved_nx_s = HZ_RUN;
      cnt_nx_s   = 2'd0;
    end else if (dmem_busy) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      state_nx_s = HZ_WAIT;
      saved_nx_s = eff_state_s;
    end else if (br_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      cnt_nx_s   = FLUSH_RELOAD;
      state_nx_s = MULTI_FLUSH ? HZ_FLUSH : HZ_RUN;
    end else begin
      case (eff_state_s)
        HZ_FLUSH: begin
          ifid_flush = 1'b1;
          if (cnt_r == 2'd1) begin
            state_nx_s = HZ_RUN;
          end else begin
            state_nx_s = HZ_FLUSH;
            cnt_nx_s   = cnt_r - 2'd1;
          end
        end
        default: begin
          state_nx_s = HZ_RUN;
          if (load_use_s) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else begin
            pc_en      = 1'b1;
          end
        end
      endcase
    end
  end

  // Controller state, saved return state and bubble counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= HZ_RUN;
      saved_r <= HZ_RUN;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nx_s;
      saved_r <= saved_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // Saturating counters: stalls are cycles with the PC held, flushes are IF/ID NOP loads.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_en && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (ifid_flush && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
